// File: rtl/sr_bank_write_sched.sv
// Round-robin write scheduler for a shared bank of gated SR latches.
// Each granted op runs SETUP -> PULSE -> HOLD -> CHECK and reports a readback status.
module sr_bank_write_sched #(
  parameter int N_REQ     = 4,
  parameter int N_BITS    = 8,
  parameter int PULSE_CYC = 2,
  parameter int IDX_W     = (N_BITS > 1) ? $clog2(N_BITS) : 1,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_set,
  input  logic [N_REQ*IDX_W-1:0] req_idx,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_BITS-1:0]      lat_s,
  output logic [N_BITS-1:0]      lat_r,
  output logic [N_BITS-1:0]      lat_en,
  input  logic [N_BITS-1:0]      lat_q,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic                   done_ok,
  output logic [2:0]             dbg_state
);

  // Handshake: a requester holds req_valid/req_set/req_idx stable until it sees its
  // one-cycle req_ready pulse; the op is accepted in that cycle and inputs are then free.
  localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [ID_W-1:0]    rr_ptr, nxt_rr;
  logic               cap_set, nxt_set;
  logic [IDX_W-1:0]   cap_idx, nxt_idx;
  logic [ID_W-1:0]    cap_id, nxt_id;
  logic [N_REQ-1:0]   nxt_ready;
  logic [N_BITS-1:0]  nxt_s, nxt_r, nxt_en, sel;
  logic               nxt_done, nxt_ok, in_range, found;
  logic [ID_W-1:0]    j, gnt;
  logic [IDX_W-1:0]   idx_arr [N_REQ];

  assign dbg_state = state;
  assign in_range  = (int'(cap_idx) < N_BITS);
  assign sel       = in_range ? (N_BITS'(1) << cap_idx) : '0;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) idx_arr[i] = req_idx[i*IDX_W +: IDX_W];
  end

  // Outputs are computed from the current state and registered, so the pins
  // trail the state by one cycle: grant at t, s/r at t+1, done at t+PULSE_CYC+3.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_rr    = rr_ptr;
    nxt_set   = cap_set;
    nxt_idx   = cap_idx;
    nxt_id    = cap_id;
    nxt_ready = '0;
    nxt_s     = '0;
    nxt_r     = '0;
    nxt_en    = '0;
    nxt_done  = 1'b0;
    nxt_ok    = 1'b0;
    found     = 1'b0;
    j         = rr_ptr;
    gnt       = rr_ptr;
    case (state)
      IDLE: begin
        for (int k = 0; k < N_REQ; k++) begin
          if (!found && req_valid[j]) begin
            found = 1'b1;
            gnt   = j;
          end
          j = (j == ID_W'(N_REQ-1)) ? '0 : j + ID_W'(1);
        end
        if (found) begin
          nxt_ready = N_REQ'(1) << gnt;
          nxt_set   = req_set[gnt];
          nxt_idx   = idx_arr[gnt];
          nxt_id    = gnt;
          nxt_rr    = (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + ID_W'(1);
          nxt_state = SETUP;
        end
      end
      SETUP: begin
        nxt_s     = cap_set ? sel : '0;
        nxt_r     = cap_set ? '0 : sel;
        nxt_cnt   = '0;
        nxt_state = PULSE;
      end
      PULSE: begin
        nxt_s  = cap_set ? sel : '0;
        nxt_r  = cap_set ? '0 : sel;
        nxt_en = sel;
        if (cnt == CNT_W'(PULSE_CYC-1)) begin
          nxt_cnt   = '0;
          nxt_state = HOLD;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        nxt_s     = cap_set ? sel : '0;
        nxt_r     = cap_set ? '0 : sel;
        nxt_state = CHECK;
      end
      CHECK: begin
        nxt_done  = 1'b1;
        nxt_ok    = in_range && ((|(lat_q & sel)) == cap_set);
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      cap_set   <= 1'b0;
      cap_idx   <= '0;
      cap_id    <= '0;
      req_ready <= '0;
      lat_s     <= '0;
      lat_r     <= '0;
      lat_en    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      done_ok   <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      rr_ptr    <= nxt_rr;
      cap_set   <= nxt_set;
      cap_idx   <= nxt_idx;
      cap_id    <= nxt_id;
      req_ready <= nxt_ready;
      lat_s     <= nxt_s;
      lat_r     <= nxt_r;
      lat_en    <= nxt_en;
      busy      <= (state != IDLE);
      done      <= nxt_done;
      done_id   <= nxt_done ? cap_id : '0;
      done_ok   <= nxt_ok;
    end
  end

endmodule

// File: tb/tb_sr_bank_write_sched.sv
// Bench for sr_bank_write_sched: latch-bank model, timeline reference model of each op,
// directed scenarios followed by randomized request bursts.
module tb_sr_bank_write_sched;

  localparam int N_REQ     = 4;
  localparam int N_BITS    = 8;
  localparam int PULSE_CYC = 2;
  localparam int IDX_W     = 4;
  localparam int ID_W      = 2;
  localparam int LAT       = PULSE_CYC + 3;

  logic                   clk = 1'b0;
  logic                   nrst = 1'b0;
  logic [N_REQ-1:0]       req_valid, req_set, req_ready;
  logic [N_REQ*IDX_W-1:0] req_idx;
  logic [N_BITS-1:0]      lat_s, lat_r, lat_en, lat_q;
  logic                   busy, done, done_ok;
  logic [ID_W-1:0]        done_id;
  logic [2:0]             dbg_state;

  sr_bank_write_sched #(.N_REQ(N_REQ), .N_BITS(N_BITS), .PULSE_CYC(PULSE_CYC), .IDX_W(IDX_W)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_set(req_set), .req_idx(req_idx),
    .req_ready(req_ready), .lat_s(lat_s), .lat_r(lat_r), .lat_en(lat_en), .lat_q(lat_q),
    .busy(busy), .done(done), .done_id(done_id), .done_ok(done_ok), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- latch bank model ----------------
  logic [N_BITS-1:0] q_store = '0;
  logic [N_BITS-1:0] stuck0 = '0;

  always @(lat_s or lat_r or lat_en) begin
    for (int k = 0; k < N_BITS; k++)
      if (lat_en[k]) begin
        if (lat_s[k]) q_store[k] = 1'b1;
        else if (lat_r[k]) q_store[k] = 1'b0;
      end
  end
  assign lat_q = q_store & ~stuck0;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- requester drivers ----------------
  logic [N_REQ-1:0] r_valid = '0;
  logic [N_REQ-1:0] r_set = '0;
  logic [IDX_W-1:0] r_idx [N_REQ];
  logic [IDX_W:0]   pend [N_REQ][$];

  assign req_valid = r_valid;
  assign req_set   = r_set;
  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_idx[i*IDX_W +: IDX_W] = r_idx[i];
  end

  task automatic push_op(input int r, input logic s, input logic [IDX_W-1:0] i);
    pend[r].push_back({s, i});
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [ID_W:0] exp_q[$];           // {done_id, done_ok} per accepted op
  int            cyc, free_cyc, rr_ptr, act_t;
  logic          act_v = 1'b0;
  logic          act_set;
  logic [IDX_W-1:0] act_idx;
  logic [N_BITS-1:0] prev_s, prev_r, prev_en;

  initial begin
    for (int i = 0; i < N_REQ; i++) r_idx[i] = '0;
  end

  always @(negedge clk) begin
    int d, g;
    logic [N_BITS-1:0] bitv, e_s, e_r, e_en;
    logic e_busy, e_done, ok, s_now;
    logic [N_REQ-1:0] e_ready;
    logic [IDX_W:0] e;
    logic [ID_W:0] rec;
    if (!nrst) begin
      cyc = 0; free_cyc = 0; rr_ptr = 0; act_v = 1'b0;
      exp_q.delete();
      r_valid = '0;
      prev_s = '0; prev_r = '0; prev_en = '0;
    end else begin
      cyc++;
      d    = cyc - act_t;
      bitv = (act_v && act_idx < IDX_W'(N_BITS)) ? (N_BITS'(1) << act_idx) : '0;
      e_s    = (act_v && d >= 1 && d <= PULSE_CYC + 2 && act_set)  ? bitv : '0;
      e_r    = (act_v && d >= 1 && d <= PULSE_CYC + 2 && !act_set) ? bitv : '0;
      e_en   = (act_v && d >= 2 && d <= PULSE_CYC + 1) ? bitv : '0;
      e_busy = act_v && d >= 1 && d <= LAT;
      e_done = act_v && d == LAT;
      check("lat_s", 32'(lat_s), 32'(e_s));
      check("lat_r", 32'(lat_r), 32'(e_r));
      check("lat_en", 32'(lat_en), 32'(e_en));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      if (e_done) begin
        rec = exp_q.pop_front();
        check("done_id", 32'(done_id), 32'(rec[ID_W:1]));
        check("done_ok", 32'(done_ok), 32'(rec[0]));
        act_v = 1'b0;
      end
      // safety invariants of the latch sequencing
      check("s_and_r", 32'(lat_s & lat_r), 32'd0);
      check("en_onehot0", 32'($countones(lat_en) <= 1), 32'd1);
      if (lat_en != '0 || prev_en != '0)
        check("sr_stable_en", 32'({lat_s, lat_r}), 32'({prev_s, prev_r}));
      prev_s = lat_s; prev_r = lat_r; prev_en = lat_en;
      // grant expectation: strict round robin once the scheduler is free again
      e_ready = '0;
      g = -1;
      if (cyc - 1 >= free_cyc && r_valid != '0) begin
        for (int k = 0; k < N_REQ; k++)
          if (g < 0 && r_valid[(rr_ptr + k) % N_REQ]) g = (rr_ptr + k) % N_REQ;
        e_ready = N_REQ'(1) << g;
        s_now   = r_set[g];
        ok      = (r_idx[g] < IDX_W'(N_BITS)) && !(s_now && stuck0[r_idx[g][2:0]]);
        exp_q.push_back({ID_W'(g), ok});
        act_v = 1'b1; act_t = cyc; act_set = s_now; act_idx = r_idx[g];
        rr_ptr   = (g + 1) % N_REQ;
        free_cyc = cyc + LAT;
      end
      check("req_ready", 32'(req_ready), 32'(e_ready));
      // requesters: release on accept, then present the next queued op
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i]) r_valid[i] = 1'b0;
        if (!r_valid[i] && pend[i].size() > 0) begin
          e = pend[i].pop_front();
          r_set[i] = e[IDX_W];
          r_idx[i] = e[IDX_W-1:0];
          r_valid[i] = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_lat"}, 32'({lat_s, lat_r, lat_en}), 32'd0);
    check({tag, "_flags"}, 32'({busy, done, done_id, done_ok}), 32'd0);
  endtask

  task automatic reset_now(input string tag);
    #2 nrst = 1'b0;
    #1 check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    #2 nrst = 1'b1;
  endtask

  task automatic wait_idle();
    logic idle = 1'b0;
    for (int c = 0; c < 400 && !idle; c++) begin
      @(posedge clk);
      idle = (r_valid == '0) && !act_v;
      for (int i = 0; i < N_REQ; i++) if (pend[i].size() > 0) idle = 1'b0;
    end
    check("wait_idle_done", 32'(idle), 32'd1);
    @(posedge clk);
  endtask

  initial begin
    logic seen_en;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 nrst = 1'b1;
    @(posedge clk);

    // single set then reset of latch 3
    push_op(0, 1'b1, 4'd3);
    wait_idle();
    check("q3_after_set", 32'(lat_q[3]), 32'd1);
    push_op(1, 1'b0, 4'd3);
    wait_idle();
    check("q3_after_reset", 32'(lat_q[3]), 32'd0);

    // all requesters pending from reset: grants 0,1,2,3,0
    @(posedge clk);
    reset_now("rst_rr");
    @(posedge clk);
    push_op(0, 1'b1, 4'd0); push_op(0, 1'b0, 4'd0);
    push_op(1, 1'b1, 4'd1); push_op(2, 1'b1, 4'd2); push_op(3, 1'b1, 4'd4);
    wait_idle();

    // stuck-at-0 latch 5
    stuck0 = 8'h20;
    push_op(2, 1'b1, 4'd5);
    wait_idle();
    stuck0 = '0;

    // reset while en is high, then a clean op afterwards
    push_op(0, 1'b1, 4'd6);
    seen_en = 1'b0;
    for (int c = 0; c < 50 && !seen_en; c++) begin
      @(posedge clk);
      #1 seen_en = (lat_en != '0);
    end
    check("en_reached", 32'(seen_en), 32'd1);
    reset_now("rst_pulse");
    push_op(3, 1'b0, 4'd6);
    wait_idle();

    // out-of-range index
    push_op(3, 1'b1, 4'd9);
    wait_idle();

    // randomized bursts
    for (int b = 0; b < 30; b++) begin
      stuck0 = ($urandom_range(0, 3) == 0) ? (N_BITS'(1) << $urandom_range(0, N_BITS-1)) : '0;
      for (int n = 0; n < int'($urandom_range(1, 5)); n++)
        push_op(int'($urandom_range(0, N_REQ-1)), 1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 9)));
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
